// File: rtl/fir_sched_pkg.sv
// Shared types, constants and helpers for the two-channel FIR sample scheduler.
package fir_sched_pkg;

    localparam int unsigned DIN_W  = 16;
    localparam int unsigned DOUT_W = 18;

    // FIR channel-select encoding
    localparam logic CH_A = 1'b1;
    localparam logic CH_B = 1'b0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_A  = 2'd1,
        WAIT_GAP = 2'd2,
        ISSUE_B  = 2'd3
    } state_t;

    // Bits needed to hold values 0..v-1 (at least one bit)
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/fir_chan_sched_if.sv
// Scheduler <-> rx_fir bus: new-data issue path and result return path.
interface fir_chan_sched_if;
    import fir_sched_pkg::*;

    logic              sclr;
    logic              nd;
    logic [DIN_W-1:0]  din;
    logic              chan_in;
    logic              rdy;
    logic [DOUT_W-1:0] dout;
    logic              chan_out;

    modport master (
        output sclr, nd, din, chan_in,
        input  rdy, dout, chan_out
    );

    modport slave (
        input  sclr, nd, din, chan_in,
        output rdy, dout, chan_out
    );

endinterface

// File: rtl/fir_rate_div.sv
// Sample-period divider: counts 0..DIV-1 while enabled and flags the last count.
module fir_rate_div
    import fir_sched_pkg::*;
#(
    parameter int unsigned DIV = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned CNT_W = clog2(DIV);

    logic [CNT_W-1:0] cnt;

    // Divider counter; held at zero while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == CNT_W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick_c = en && (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/fir_chan_sched.sv
// Two-channel sample scheduler for the shared rx_fir: issues A/B sample pairs,
// demultiplexes results and flags overrun / handshake errors.
module fir_chan_sched
    import fir_sched_pkg::*;
#(
    parameter int unsigned DIV     = 64,
    parameter int unsigned GAP     = 2,
    parameter int unsigned TIMEOUT = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr_err,
    input  logic [DIN_W-1:0]        din_a,
    input  logic [DIN_W-1:0]        din_b,
    output logic                    sample_tick,
    fir_chan_sched_if.master        fir,
    output logic [DOUT_W-1:0]       dout_a,
    output logic [DOUT_W-1:0]       dout_b,
    output logic                    vld_a,
    output logic                    vld_b,
    output logic                    busy,
    output logic                    overrun,
    output logic                    proto_err
);

    localparam int unsigned GAP_W    = clog2(GAP);
    localparam int unsigned GAP_LAST = (GAP >= 2) ? GAP - 2 : 0;
    localparam int unsigned TO_W     = clog2(TIMEOUT);
    localparam int unsigned OUT_W    = 2;

    if (DIV < GAP + 3 || GAP < 1) begin : g_param_check
        $error("fir_chan_sched: requires DIV >= GAP+3 and GAP >= 1");
    end

    logic              tick_c;
    state_t            state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DIN_W-1:0]  hold_b_q, hold_b_d;
    logic              nd_q, nd_d;
    logic [DIN_W-1:0]  din_q, din_d;
    logic              chan_q, chan_d;
    logic              sclr_q;
    logic [OUT_W-1:0]  out_q, out_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              ovr_q, ovr_d;
    logic              perr_q, perr_d;
    logic              busy_q;
    logic [DOUT_W-1:0] dout_a_q, dout_b_q;
    logic              vld_a_q, vld_b_q;
    logic              spur_c, stall_c, tmo_c;

    fir_rate_div #(.DIV(DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .tick_c (tick_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    // Next state and next issue-register values; a pair always completes once started
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        hold_b_d = hold_b_q;
        nd_d     = 1'b0;
        din_d    = din_q;
        chan_d   = chan_q;
        unique case (state_q)
            IDLE: begin
                if (tick_c) begin
                    state_d  = ISSUE_A;
                    hold_b_d = din_b;
                    nd_d     = 1'b1;
                    din_d    = din_a;
                    chan_d   = CH_A;
                end
            end
            ISSUE_A: begin
                if (GAP == 1) begin
                    state_d = ISSUE_B;
                    nd_d    = 1'b1;
                    din_d   = hold_b_q;
                    chan_d  = CH_B;
                end else begin
                    state_d = WAIT_GAP;
                    gap_d   = '0;
                end
            end
            WAIT_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = ISSUE_B;
                    nd_d    = 1'b1;
                    din_d   = hold_b_q;
                    chan_d  = CH_B;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ISSUE_B: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outstanding-result tracking, timeout and sticky error flags
    always_comb begin
        spur_c  = fir.rdy && (out_q == '0);
        stall_c = (out_q != '0) && !fir.rdy;
        tmo_c   = stall_c && (to_q == TO_W'(TIMEOUT - 1));
        to_d    = (stall_c && !tmo_c) ? to_q + TO_W'(1) : '0;
        out_d   = out_q;
        if (tmo_c) begin
            out_d = '0;
        end else if (nd_q && !fir.rdy) begin
            out_d = (out_q == OUT_W'(2)) ? out_q : out_q + OUT_W'(1);
        end else if (!nd_q && fir.rdy) begin
            out_d = (out_q == '0) ? out_q : out_q - OUT_W'(1);
        end
        ovr_d  = (tick_c && (out_q != '0)) || (ovr_q && !clr_err);
        perr_d = spur_c || tmo_c || (perr_q && !clr_err);
    end

    // Issue registers, counters, flags and result demux
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_b_q <= '0;
            nd_q     <= 1'b0;
            din_q    <= '0;
            chan_q   <= 1'b0;
            sclr_q   <= 1'b1;
            out_q    <= '0;
            to_q     <= '0;
            ovr_q    <= 1'b0;
            perr_q   <= 1'b0;
            busy_q   <= 1'b0;
            dout_a_q <= '0;
            dout_b_q <= '0;
            vld_a_q  <= 1'b0;
            vld_b_q  <= 1'b0;
        end else begin
            hold_b_q <= hold_b_d;
            nd_q     <= nd_d;
            din_q    <= din_d;
            chan_q   <= chan_d;
            sclr_q   <= 1'b0;
            out_q    <= out_d;
            to_q     <= to_d;
            ovr_q    <= ovr_d;
            perr_q   <= perr_d;
            busy_q   <= (state_d != IDLE) || (out_d != '0);
            vld_a_q  <= fir.rdy && (fir.chan_out == CH_A);
            vld_b_q  <= fir.rdy && (fir.chan_out == CH_B);
            if (fir.rdy && fir.chan_out == CH_A) begin
                dout_a_q <= fir.dout;
            end
            if (fir.rdy && fir.chan_out == CH_B) begin
                dout_b_q <= fir.dout;
            end
        end
    end

    assign sample_tick = tick_c;
    assign fir.sclr    = sclr_q;
    assign fir.nd      = nd_q;
    assign fir.din     = din_q;
    assign fir.chan_in = chan_q;
    assign dout_a      = dout_a_q;
    assign dout_b      = dout_b_q;
    assign vld_a       = vld_a_q;
    assign vld_b       = vld_b_q;
    assign busy        = busy_q;
    assign overrun     = ovr_q;
    assign proto_err   = perr_q;

endmodule
